// File: rtl/read_level_ctrl.sv
// Read-side controller of an asynchronous FIFO. It owns the read pointer,
// synchronises the write pointer into rclk, and produces registered empty,
// almost-empty and fill-level outputs plus a sticky underflow flag.
module read_level_ctrl #(
  parameter int A_SIZE      = 4,
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic              rclk,
  input  logic              rrstn,
  input  logic              ren,
  input  logic [A_SIZE:0]   wptr,
  input  logic [A_SIZE:0]   aempty_thr,
  input  logic              clr_err,
  output logic [A_SIZE-1:0] raddr,
  output logic [A_SIZE:0]   rptr,
  output logic              empty,
  output logic              aempty,
  output logic [A_SIZE:0]   rcount,
  output logic              underflow
);

  localparam int PW = A_SIZE + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wsync;
  logic [PW-1:0] wbin_s;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] count_next;
  logic          rd_ok;

  // Plain flop chain for the Gray write pointer; nothing sits between stages
  // so only one bit can be in transition at any time.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wsync = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i < PW; i++) wbin_s[i] = ^(wsync >> i);
  end

  // A read is only honoured while the FIFO holds data.
  assign rd_ok      = ren & ~empty;
  assign rbin_next  = rbin + PW'(rd_ok);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);
  assign count_next = wbin_s - rbin_next;

  // Binary and Gray read pointers move together so rptr is glitch-free.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      rbin  <= '0;
      rgray <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
    end
  end

  assign raddr = rbin[A_SIZE-1:0];
  assign rptr  = rgray;

  // Level flags look ahead at the post-read pointer, so empty rises on the
  // same edge that consumes the last word.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      empty  <= 1'b1;
      aempty <= 1'b1;
      rcount <= '0;
    end else begin
      empty  <= (rgray_next == wsync);
      aempty <= (count_next <= aempty_thr);
      rcount <= count_next;
    end
  end

  // Sticky underflow; a new violation takes priority over a clear request.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      underflow <= 1'b0;
    end else if (ren && empty) begin
      underflow <= 1'b1;
    end else if (clr_err) begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_level_ctrl.sv
// Directed bench for read_level_ctrl (A_SIZE=4, SYNC_STAGES=2). Expected
// output snapshots are queued as each step is driven and checked after the
// following edge.
module tb_read_level_ctrl;

  logic       rclk;
  logic       rrstn;
  logic       ren;
  logic [4:0] wptr;
  logic [4:0] aempty_thr;
  logic       clr_err;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       empty;
  logic       aempty;
  logic [4:0] rcount;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       empty;
    logic       aempty;
    logic [4:0] rcount;
    logic       underflow;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  sb_t sb_q[$];

  read_level_ctrl #(.A_SIZE(4), .SYNC_STAGES(2)) dut (
    .rclk       (rclk),
    .rrstn      (rrstn),
    .ren        (ren),
    .wptr       (wptr),
    .aempty_thr (aempty_thr),
    .clr_err    (clr_err),
    .raddr      (raddr),
    .rptr       (rptr),
    .empty      (empty),
    .aempty     (aempty),
    .rcount     (rcount),
    .underflow  (underflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] gray(int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  // Expected snapshot from the read pointer position in binary.
  function automatic obs_t mk(int b, bit e, bit ae, int rc, bit uf);
    obs_t o;
    logic [4:0] bv;
    bv          = b[4:0];
    o.raddr     = bv[3:0];
    o.rptr      = gray(b);
    o.empty     = e;
    o.aempty    = ae;
    o.rcount    = rc[4:0];
    o.underflow = uf;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("raddr=%0d rptr=%b empty=%b aempty=%b rcount=%0d underflow=%b",
                     o.raddr, o.rptr, o.empty, o.aempty, o.rcount, o.underflow);
  endfunction

  task automatic push(string tag, obs_t e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic compare_front();
    sb_t  s;
    obs_t o;
    s = sb_q.pop_front();
    o = '{raddr, rptr, empty, aempty, rcount, underflow};
    checks++;
    assert (o === s.exp) else begin
      errors++;
      $error("FAIL %s: observed %s expected %s", s.tag, fmt(o), fmt(s.exp));
    end
  endtask

  // Output expected right now (asynchronous reset behaviour).
  task automatic now(string tag, obs_t e);
    push(tag, e);
    compare_front();
  endtask

  // Output expected after the next rising edge.
  task automatic tick(string tag, obs_t e);
    push(tag, e);
    @(posedge rclk);
    #1;
    compare_front();
  endtask

  initial begin
    rrstn      = 1'b0;
    ren        = 1'b1;
    wptr       = 5'b00010;
    aempty_thr = 5'd0;
    clr_err    = 1'b0;
    repeat (2) @(posedge rclk);
    #1;
    now("reset", mk(0, 1, 1, 0, 0));

    // Simple read: three words become visible after the synchroniser.
    ren   = 1'b0;
    rrstn = 1'b1;
    tick("sync_e1", mk(0, 1, 1, 0, 0));
    tick("sync_e2", mk(0, 1, 1, 0, 0));
    tick("sync_e3", mk(0, 0, 0, 3, 0));
    ren = 1'b1;
    for (int k = 1; k <= 3; k++)
      tick($sformatf("read_%0d", k), mk(k, k == 3, k == 3, 3 - k, 0));

    // Underflow set, hold, clear and set-wins-over-clear.
    tick("uf_set", mk(3, 1, 1, 0, 1));
    ren = 1'b0;
    tick("uf_hold", mk(3, 1, 1, 0, 1));
    clr_err = 1'b1;
    tick("uf_clr", mk(3, 1, 1, 0, 0));
    ren = 1'b1;
    tick("uf_set_wins", mk(3, 1, 1, 0, 1));
    ren     = 1'b0;
    clr_err = 1'b0;
    tick("uf_sticky", mk(3, 1, 1, 0, 1));
    clr_err = 1'b1;
    tick("uf_clr2", mk(3, 1, 1, 0, 0));
    clr_err = 1'b0;

    // Full FIFO and wrap-around over a complete pass.
    rrstn = 1'b0;
    #1;
    now("reset_async", mk(0, 1, 1, 0, 0));
    wptr = 5'b11000;
    @(posedge rclk);
    #1;
    rrstn = 1'b1;
    tick("full_e1", mk(0, 1, 1, 0, 0));
    tick("full_e2", mk(0, 1, 1, 0, 0));
    tick("full_e3", mk(0, 0, 0, 16, 0));
    ren = 1'b1;
    for (int k = 1; k <= 16; k++)
      tick($sformatf("wrap_%0d", k), mk(k, k == 16, k == 16, 16 - k, 0));
    ren = 1'b0;
    checks++;
    assert (rptr === 5'b11000) else begin
      errors++;
      $error("FAIL wrap_rptr: observed %b expected %b", rptr, 5'b11000);
    end

    // Almost-empty threshold of 2 with four words.
    aempty_thr = 5'd2;
    wptr       = gray(20);
    tick("ae_e1", mk(16, 1, 1, 0, 0));
    tick("ae_e2", mk(16, 1, 1, 0, 0));
    tick("ae_e3", mk(16, 0, 0, 4, 0));
    ren = 1'b1;
    for (int k = 1; k <= 4; k++)
      tick($sformatf("ae_read_%0d", k), mk(16 + k, k == 4, (4 - k) <= 2, 4 - k, 0));
    ren = 1'b0;

    // Reset pulsed in the middle of a burst.
    wptr = gray(25);
    tick("mb_e1", mk(20, 1, 1, 0, 0));
    tick("mb_e2", mk(20, 1, 1, 0, 0));
    tick("mb_e3", mk(20, 0, 0, 5, 0));
    ren = 1'b1;
    tick("mb_read_1", mk(21, 0, 0, 4, 0));
    tick("mb_read_2", mk(22, 0, 0, 3, 0));
    #3;
    rrstn = 1'b0;
    #1;
    now("mb_reset_now", mk(0, 1, 1, 0, 0));
    wptr = 5'b00000;
    ren  = 1'b0;
    @(posedge rclk);
    #1;
    now("mb_reset_held", mk(0, 1, 1, 0, 0));
    rrstn = 1'b1;
    tick("mb_idle_1", mk(0, 1, 1, 0, 0));
    tick("mb_idle_2", mk(0, 1, 1, 0, 0));
    wptr = gray(2);
    tick("mb_resync_1", mk(0, 1, 1, 0, 0));
    tick("mb_resync_2", mk(0, 1, 1, 0, 0));
    tick("mb_resync_3", mk(0, 0, 1, 2, 0));

    checks++;
    assert (sb_q.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/read_level_ctrl.md
READ_LEVEL_CTRL -- requirements
Module: read_level_ctrl

Interface
REQ-001 SHALL have parameter A_SIZE, default 4, address width; FIFO depth is 2^A_SIZE; pointers are A_SIZE+1 bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of write-pointer synchroniser flops; legal range 2..4.
REQ-003 SHALL have port rclk, input, 1, the single read-domain clock; all flops on its rising edge.
REQ-004 SHALL have port rrstn, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port ren, input, 1, read request.
REQ-006 SHALL have port wptr, input, A_SIZE+1, Gray-coded write pointer from the write domain.
REQ-007 SHALL have port aempty_thr, input, A_SIZE+1, almost-empty threshold; quasi-static binary value.
REQ-008 SHALL have port clr_err, input, 1, clears the sticky underflow flag.
REQ-009 SHALL have port raddr, output, A_SIZE, binary RAM read address.
REQ-010 SHALL have port rptr, output, A_SIZE+1, registered Gray read pointer to the write domain.
REQ-011 SHALL have port empty, output, 1, registered empty flag.
REQ-012 SHALL have port aempty, output, 1, registered almost-empty flag.
REQ-013 SHALL have port rcount, output, A_SIZE+1, registered fill level, range 0..2^A_SIZE.
REQ-014 SHALL have port underflow, output, 1, sticky error: read requested while empty.

Function
REQ-015 SHALL accept a read only when ren=1 and empty=0; rbin_next = rbin + accepted, modulo 2^(A_SIZE+1).
REQ-016 SHALL register rbin and rgray = rbin ^ (rbin>>1) together on each edge; raddr = rbin[A_SIZE-1:0], rptr = rgray.
REQ-017 SHALL pass wptr through a SYNC_STAGES-deep flop chain; the last stage is wsync; no logic between stages.
REQ-018 SHALL convert wsync from Gray to binary (wbin_s) combinationally, bit i = XOR of wsync[A_SIZE:i].
REQ-019 SHALL register empty <= (rgray_next == wsync), so empty asserts on the same edge that consumes the last word.
REQ-020 SHALL register rcount <= (wbin_s - rbin_next) modulo 2^(A_SIZE+1).
REQ-021 SHALL register aempty <= (count_next <= aempty_thr); aempty_thr=0 makes aempty equal empty.
REQ-022 SHALL set underflow on the edge after ren=1 while empty=1; pointers are unchanged and no read is accepted.
REQ-023 SHALL clear underflow when clr_err=1; when set and clear occur in the same cycle, set wins.
REQ-024 SHALL show a wptr change on empty, aempty and rcount exactly SYNC_STAGES+1 rclk edges after wptr is stable.
REQ-025 SHALL wrap raddr from 2^A_SIZE-1 to 0 and toggle the rptr MSB on every full pass, with continuous reads at full rate.
REQ-026 SHALL count a full FIFO (pointer difference 2^A_SIZE) as rcount=2^A_SIZE; a difference above 2^A_SIZE is undefined.

Reset
REQ-027 SHALL, while rrstn=0, force rbin=0, rgray=0, all sync stages=0, empty=1, aempty=1, rcount=0, underflow=0, independent of rclk.
REQ-028 SHALL resume normal operation on the first rclk edge after rrstn rises; reset asserted mid-burst discards any in-flight read.

Verification (A_SIZE=4, SYNC_STAGES=2)
REQ-029 SHALL cover reset: rrstn=0 with ren=1 and wptr=5'b00010 -> raddr=0, rptr=0, empty=1, aempty=1, rcount=0, underflow=0.
REQ-030 SHALL cover a simple read: wptr=gray(3)=5'b00010 held -> empty falls on the 3rd edge with rcount=3; then ren=1 for 3 cycles -> raddr 0,1,2; rptr 00001,00011,00010; empty=1 and rcount=0 after the 3rd read.
REQ-031 SHALL cover underflow: ren=1 while empty=1 -> rptr unchanged, underflow=1 on the next edge and held; clr_err=1 with ren=0 -> underflow=0 on the next edge; clr_err=1 with ren=1 while empty -> underflow stays 1.
REQ-032 SHALL cover wrap: FIFO full with wptr=gray(16)=5'b11000 and rptr=0 -> rcount=16; 16 back-to-back reads -> raddr 0..15, rptr=5'b11000 at the end, empty=1 only after the 16th read.
REQ-033 SHALL cover almost-empty: aempty_thr=2 with rcount=4 -> aempty=0; after 2 reads rcount=2 and aempty=1; after 2 more reads empty=1.
REQ-034 SHALL cover reset mid-burst: rrstn pulsed low between edges during continuous reads with rcount=5 -> outputs take reset values immediately without an edge, and empty stays 1 until wptr resynchronises.
